// File: rtl/dsp_mac_sequencer_pkg.sv
// rtl/dsp_mac_sequencer_pkg.sv - shared types and OPMODE constants for the DSP MAC sequencer
package dsp_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
    localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
    localparam logic [7:0] OPM_CLR   = 8'b0000_0000;
    localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;

    localparam int P_LAT_DEF = 3;

    // A slot with no beat must leave P untouched once the job has produced a product.
    function automatic logic [7:0] slot_opmode(input logic fire, input logic started);
        if (fire) return started ? OPM_ACC : OPM_FIRST;
        return started ? OPM_HOLD : OPM_CLR;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - operand stream and result handshake bundle
interface dsp_mac_sequencer_if;
    logic               s_valid;
    logic               s_ready;
    logic signed [17:0] s_a;
    logic signed [17:0] s_b;
    logic               r_valid;
    logic               r_ready;
    logic signed [47:0] r_p;

    modport slave  (input  s_valid, s_a, s_b, r_ready, output s_ready, r_valid, r_p);
    modport master (output s_valid, s_a, s_b, r_ready, input  s_ready, r_valid, r_p);
endinterface

// File: rtl/dsp_mac_sequencer_rst_sync.sv
// rtl/dsp_mac_sequencer_rst_sync.sv - async-assert, sync-release reset for the DSP slice
module dsp_rst_sync #(
    parameter int HOLD = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic dsp_rst_o
);

    logic [HOLD-1:0] sr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sr_q <= '1;
        else         sr_q <= sr_q << 1;
    end

    assign dsp_rst_o = sr_q[HOLD-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - drives one DSP48A1 slice to compute a signed dot product
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int P_LAT    = P_LAT_DEF,
    parameter int RST_HOLD = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   len_i,
    dsp_mac_sequencer_if.slave bus,
    output logic               busy_o,
    output logic signed [17:0] dsp_a_o,
    output logic signed [17:0] dsp_b_o,
    output logic [7:0]         dsp_opmode_o,
    output logic               dsp_rst_o,
    input  logic signed [47:0] dsp_p_i
);

    localparam int DW = (P_LAT < 1) ? 1 : $clog2(P_LAT + 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               started_q, started_d;
    logic [7:0]         opm_tag_q, opm_tag_d;
    logic [7:0]         opmode_q, opmode_d;
    logic signed [17:0] a_q, a_d, b_q, b_d;
    logic               r_valid_q, r_valid_d;
    logic signed [47:0] r_p_q, r_p_d;
    logic               s_ready;
    logic               fire;

    dsp_rst_sync #(.HOLD(RST_HOLD)) u_rst_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .dsp_rst_o (dsp_rst_o)
    );

    assign s_ready = (state_q == RUN);
    assign fire    = bus.s_valid && s_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            drain_q   <= '0;
            started_q <= 1'b0;
            opm_tag_q <= OPM_CLR;
            opmode_q  <= OPM_CLR;
            a_q       <= '0;
            b_q       <= '0;
            r_valid_q <= 1'b0;
            r_p_q     <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            drain_q   <= drain_d;
            started_q <= started_d;
            opm_tag_q <= opm_tag_d;
            opmode_q  <= opmode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_valid_q <= r_valid_d;
            r_p_q     <= r_p_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        drain_d   = drain_q;
        started_d = started_q;
        a_d       = a_q;
        b_d       = b_q;
        r_valid_d = r_valid_q;
        r_p_d     = r_p_q;
        // The tag lags the operands by one edge so the DSP OPMODE register lines up with M.
        opm_tag_d = slot_opmode(fire, started_q);
        opmode_d  = opm_tag_q;

        if (fire) begin
            a_d       = bus.s_a;
            b_d       = bus.s_b;
            started_d = 1'b1;
            rem_d     = rem_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                started_d = 1'b0;
                if (start_i) begin
                    if (len_i == '0) begin
                        r_p_d     = '0;
                        r_valid_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        rem_d   = len_i;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (fire && rem_q == LEN_W'(1)) begin
                    drain_d = DW'(P_LAT);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    r_p_d     = dsp_p_i;
                    r_valid_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_ready   = s_ready;
    assign bus.r_valid   = r_valid_q;
    assign bus.r_p       = r_p_q;
    assign busy_o        = (state_q != IDLE);
    assign dsp_a_o       = a_q;
    assign dsp_b_o       = b_q;
    assign dsp_opmode_o  = opmode_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - randomized self-checking bench with a DSP48A1 slice model
module tb_dsp_mac_sequencer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         len;
    logic               busy;
    logic signed [17:0] dsp_a, dsp_b;
    logic [7:0]         dsp_opmode;
    logic               dsp_rst;
    logic signed [47:0] dsp_p;

    always #10 clk = ~clk;

    dsp_mac_sequencer_if bus();

    dsp_mac_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .len_i        (len),
        .bus          (bus),
        .busy_o       (busy),
        .dsp_a_o      (dsp_a),
        .dsp_b_o      (dsp_b),
        .dsp_opmode_o (dsp_opmode),
        .dsp_rst_o    (dsp_rst),
        .dsp_p_i      (dsp_p)
    );

    // DSP48A1 slice: A1/B1, M, OPMODE and P registers, synchronous reset, CE tied high.
    logic signed [17:0] a1_r, b1_r;
    logic signed [35:0] m_r;
    logic [7:0]         opm_r;
    logic signed [47:0] p_r, x_mux, z_mux;

    always_comb begin
        x_mux = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'sd0;
        z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'sd0;
    end

    always @(posedge clk) begin
        if (dsp_rst) begin
            a1_r <= '0; b1_r <= '0; m_r <= '0; opm_r <= '0; p_r <= '0;
        end else begin
            a1_r  <= dsp_a;
            b1_r  <= dsp_b;
            m_r   <= a1_r * b1_r;
            opm_r <= dsp_opmode;
            p_r   <= z_mux + x_mux;
        end
    end
    assign dsp_p = p_r;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic signed [17:0] av[64];
    logic signed [17:0] bv[64];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [47:0] ref_dot(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(av[i]) * longint'(bv[i]);
        return s[47:0];
    endfunction

    task automatic run_job(input int n, input int gap_min, input int gap_max,
                           input int hold, input bit chk_lat);
        logic [7:0]  opq[$];
        int          i = 0, gap = 0, last_fire = 0, t = 0;
        bit          started = 0;
        logic [47:0] exp;
        exp = ref_dot(n);
        @(negedge clk);
        start = 1'b1; len = n[7:0]; bus.r_ready = (hold == 0);
        @(negedge clk);
        start = 1'b0;
        while (i < n && t < 500) begin
            if (opq.size() >= 2) check_val("opmode", {56'h0, dsp_opmode}, {56'h0, opq.pop_front()});
            if (gap > 0) begin bus.s_valid = 1'b0; gap--; end
            else bus.s_valid = 1'b1;
            bus.s_a = bus.s_valid ? av[i] : 18'($urandom);
            bus.s_b = bus.s_valid ? bv[i] : 18'($urandom);
            if (bus.s_valid && bus.s_ready) begin
                opq.push_back(started ? 8'h09 : 8'h01);
                started = 1;
                i++;
                last_fire = cyc + 1;
                gap = $urandom_range(gap_max, gap_min);
            end else begin
                opq.push_back(started ? 8'h08 : 8'h00);
            end
            t++;
            @(negedge clk);
        end
        check_val("beats_taken", i, n);
        bus.s_valid = 1'b0;
        t = 0;
        while (!bus.r_valid && t < 40) begin @(negedge clk); t++; end
        check_val("r_valid_seen", {63'h0, bus.r_valid}, 64'h1);
        if (chk_lat) check_val("latency", cyc - last_fire, 4);
        check_val("r_p", {16'h0, $unsigned(bus.r_p)}, {16'h0, exp});
        for (int k = 0; k < hold; k++) begin
            check_val("hold_valid", {63'h0, bus.r_valid}, 64'h1);
            check_val("hold_rp", {16'h0, $unsigned(bus.r_p)}, {16'h0, exp});
            check_val("hold_busy", {63'h0, busy}, 64'h1);
            start = (k == 1);
            len   = 8'd3;
            @(negedge clk);
        end
        start = 1'b0;
        bus.r_ready = 1'b1;
        @(negedge clk);
        check_val("r_valid_drop", {63'h0, bus.r_valid}, 64'h0);
        check_val("idle_busy", {63'h0, busy}, 64'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"},    {63'h0, busy}, 64'h0);
        check_val({tag, "_s_ready"}, {63'h0, bus.s_ready}, 64'h0);
        check_val({tag, "_r_valid"}, {63'h0, bus.r_valid}, 64'h0);
        check_val({tag, "_r_p"},     {16'h0, $unsigned(bus.r_p)}, 64'h0);
        check_val({tag, "_dsp_a"},   {46'h0, $unsigned(dsp_a)}, 64'h0);
        check_val({tag, "_dsp_b"},   {46'h0, $unsigned(dsp_b)}, 64'h0);
        check_val({tag, "_opmode"},  {56'h0, dsp_opmode}, 64'h0);
        check_val({tag, "_dsp_rst"}, {63'h0, dsp_rst}, 64'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0;
        bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.r_ready = 1'b1;
        #25;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("dsp_rst_released", {63'h0, dsp_rst}, 64'h0);

        for (int i = 0; i < 4; i++) begin av[i] = 18'(i + 1); bv[i] = 18'sd10; end
        run_job(4, 0, 0, 0, 1);
        run_job(4, 1, 3, 0, 1);

        av[0] = 18'h3FFFB; bv[0] = 18'sd6;
        run_job(1, 0, 0, 0, 1);

        @(negedge clk); start = 1'b1; len = 8'd0;
        @(negedge clk); start = 1'b0;
        check_val("len0_r_valid", {63'h0, bus.r_valid}, 64'h1);
        check_val("len0_r_p", {16'h0, $unsigned(bus.r_p)}, 64'h0);
        check_val("len0_s_ready", {63'h0, bus.s_ready}, 64'h0);
        @(negedge clk);
        check_val("len0_drop", {63'h0, bus.r_valid}, 64'h0);
        check_val("len0_s_ready2", {63'h0, bus.s_ready}, 64'h0);

        for (int i = 0; i < 5; i++) begin av[i] = 18'($urandom); bv[i] = 18'($urandom); end
        run_job(5, 0, 1, 5, 1);

        for (int j = 0; j < 6; j++) begin
            int n;
            n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) begin av[i] = 18'($urandom); bv[i] = 18'($urandom); end
            run_job(n, 0, 2, 0, 1);
        end

        av[0] = 18'sd9; av[1] = 18'sd7; bv[0] = 18'sd2; bv[1] = 18'sd3;
        @(negedge clk); start = 1'b1; len = 8'd4;
        @(negedge clk); start = 1'b0;
        bus.s_valid = 1'b1; bus.s_a = av[0]; bus.s_b = bv[0];
        @(negedge clk); bus.s_a = av[1]; bus.s_b = bv[1];
        @(negedge clk); bus.s_valid = 1'b0;
        check_val("midrun_busy", {63'h0, busy}, 64'h1);
        #5 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_hold_edge1", {63'h0, dsp_rst}, 64'h1);
        @(negedge clk);
        check_val("rst_hold_edge2", {63'h0, dsp_rst}, 64'h0);
        check_val("abort_r_valid", {63'h0, bus.r_valid}, 64'h0);

        av[0] = 18'sd3; av[1] = 18'sd5; bv[0] = 18'sd4; bv[1] = 18'sd6;
        run_job(2, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
